// File: rtl/melody_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : melody_sequencer
//  Purpose  : Steps a 5-bit note address through the "Happy Birthday" tune,
//             holding each note for NOTE_TICKS clocks, and decodes the current
//             address into a half-period cycle count for the square-wave
//             tone generator (tone period = 2*(ciclos_de_nota+1) clocks).
//  Ports    : clk             - system clock, rising edge (12 MHz nominal)
//             rst_n           - synchronous active-low reset
//             direccion_nota  - current note address (registered, 5 bits)
//             contador_tiempo - cycles elapsed in current note (registered)
//             ciclos_de_nota  - half-period count for current note
//                               (combinational from direccion_nota)
//  Revision : 1.0 - initial release
// ============================================================================
module melody_sequencer #(
  parameter int NOTE_TICKS = 6000000,  // clocks per note, 1..2^24
  parameter int SONG_LEN   = 25        // notes before wrapping, 1..32
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [4:0]  direccion_nota,
  output logic [23:0] contador_tiempo,
  output logic [15:0] ciclos_de_nota
);

  // Terminal values; NOTE_TICKS = 2^24 still fits because we compare
  // against NOTE_TICKS-1.
  localparam logic [23:0] C_LAST_TICK = 24'(NOTE_TICKS - 1);
  localparam logic [4:0]  C_LAST_NOTE = 5'(SONG_LEN - 1);

  // Note half-period counts at 12 MHz.
  localparam logic [15:0] C_G4 = 16'd15305;
  localparam logic [15:0] C_A4 = 16'd13635;
  localparam logic [15:0] C_B4 = 16'd12148;
  localparam logic [15:0] C_C5 = 16'd11466;
  localparam logic [15:0] C_D5 = 16'd10215;
  localparam logic [15:0] C_E5 = 16'd9100;
  localparam logic [15:0] C_F5 = 16'd8589;
  localparam logic [15:0] C_G5 = 16'd7652;

  // Declaration initialisers give the reset values at power-up so the
  // outputs are defined even before the first reset edge.
  logic [4:0]  r_direccion = '0;
  logic [23:0] r_contador  = '0;
  logic [15:0] w_ciclos;
  logic        w_note_end;

  assign w_note_end = (r_contador == C_LAST_TICK);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_direccion <= '0;
      r_contador  <= '0;
    end else if (w_note_end) begin
      r_contador <= '0;
      if (r_direccion == C_LAST_NOTE) begin
        r_direccion <= '0;
      end else begin
        r_direccion <= r_direccion + 5'd1;
      end
    end else begin
      r_contador <= r_contador + 24'd1;
    end
  end

  // Zero-latency melody ROM; addresses past the tune decode to 0.
  always_comb begin
    w_ciclos = '0;
    case (r_direccion)
      5'd0:  w_ciclos = C_G4;
      5'd1:  w_ciclos = C_G4;
      5'd2:  w_ciclos = C_A4;
      5'd3:  w_ciclos = C_G4;
      5'd4:  w_ciclos = C_C5;
      5'd5:  w_ciclos = C_B4;
      5'd6:  w_ciclos = C_G4;
      5'd7:  w_ciclos = C_G4;
      5'd8:  w_ciclos = C_A4;
      5'd9:  w_ciclos = C_G4;
      5'd10: w_ciclos = C_D5;
      5'd11: w_ciclos = C_C5;
      5'd12: w_ciclos = C_G4;
      5'd13: w_ciclos = C_G4;
      5'd14: w_ciclos = C_G5;
      5'd15: w_ciclos = C_E5;
      5'd16: w_ciclos = C_C5;
      5'd17: w_ciclos = C_B4;
      5'd18: w_ciclos = C_A4;
      5'd19: w_ciclos = C_F5;
      5'd20: w_ciclos = C_F5;
      5'd21: w_ciclos = C_E5;
      5'd22: w_ciclos = C_C5;
      5'd23: w_ciclos = C_D5;
      5'd24: w_ciclos = C_C5;
      default: w_ciclos = '0;
    endcase
  end

  assign direccion_nota  = r_direccion;
  assign contador_tiempo = r_contador;
  assign ciclos_de_nota  = w_ciclos;

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_melody_sequencer
//  Purpose  : Directed self-checking bench for melody_sequencer. Five
//             instances cover the parameter corners: NOTE_TICKS=4 (reset and
//             note timing), NOTE_TICKS=2 (song wrap), NOTE_TICKS=1/SONG_LEN=32
//             (ROM sweep), NOTE_TICKS=10 (mid-note reset) and
//             NOTE_TICKS=1/SONG_LEN=1 (degenerate tune).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_melody_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0, rst_d = 1'b0, rst_e = 1'b0;

  logic [4:0]  dir_a, dir_b, dir_c, dir_d, dir_e;
  logic [23:0] cnt_a, cnt_b, cnt_c, cnt_d, cnt_e;
  logic [15:0] rom_a, rom_b, rom_c, rom_d, rom_e;

  melody_sequencer #(.NOTE_TICKS(4), .SONG_LEN(25)) u_a (
    .clk(clk), .rst_n(rst_a), .direccion_nota(dir_a),
    .contador_tiempo(cnt_a), .ciclos_de_nota(rom_a));
  melody_sequencer #(.NOTE_TICKS(2), .SONG_LEN(25)) u_b (
    .clk(clk), .rst_n(rst_b), .direccion_nota(dir_b),
    .contador_tiempo(cnt_b), .ciclos_de_nota(rom_b));
  melody_sequencer #(.NOTE_TICKS(1), .SONG_LEN(32)) u_c (
    .clk(clk), .rst_n(rst_c), .direccion_nota(dir_c),
    .contador_tiempo(cnt_c), .ciclos_de_nota(rom_c));
  melody_sequencer #(.NOTE_TICKS(10), .SONG_LEN(25)) u_d (
    .clk(clk), .rst_n(rst_d), .direccion_nota(dir_d),
    .contador_tiempo(cnt_d), .ciclos_de_nota(rom_d));
  melody_sequencer #(.NOTE_TICKS(1), .SONG_LEN(1)) u_e (
    .clk(clk), .rst_n(rst_e), .direccion_nota(dir_e),
    .contador_tiempo(cnt_e), .ciclos_de_nota(rom_e));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hand-entered melody table (half-period counts).
  function automatic logic [31:0] note_of(input int addr);
    case (addr)
      0, 1, 3, 6, 7, 9, 12, 13: note_of = 32'd15305;  // G4
      2, 8, 18:                 note_of = 32'd13635;  // A4
      5, 17:                    note_of = 32'd12148;  // B4
      4, 11, 16, 22, 24:        note_of = 32'd11466;  // C5
      10, 23:                   note_of = 32'd10215;  // D5
      15, 21:                   note_of = 32'd9100;   // E5
      19, 20:                   note_of = 32'd8589;   // F5
      14:                       note_of = 32'd7652;   // G5
      default:                  note_of = 32'd0;
    endcase
  endfunction

  // Advance n rising edges, landing on the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Power-up values before any clock edge
    #1;
    check_val("powerup_dir", 32'(dir_a), 32'd0);
    check_val("powerup_cnt", 32'(cnt_a), 32'd0);

    // ---- Instance A: reset then note timing ----
    tick(1);
    rst_a = 1'b1;
    tick(6);
    check_val("a_run_dir", 32'(dir_a), 32'd1);
    check_val("a_run_cnt", 32'(cnt_a), 32'd2);
    rst_a = 1'b0;
    tick(3);
    check_val("a_rst_dir", 32'(dir_a), 32'd0);
    check_val("a_rst_cnt", 32'(cnt_a), 32'd0);
    check_val("a_rst_rom", 32'(rom_a), 32'd15305);
    rst_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      check_val($sformatf("a_cnt_e%0d", i), 32'(cnt_a), 32'(i % 4));
      check_val($sformatf("a_dir_e%0d", i), 32'(dir_a), (i == 4) ? 32'd1 : 32'd0);
    end
    check_val("a_rom_addr1", 32'(rom_a), 32'd15305);
    tick(4);
    check_val("a_dir_addr2", 32'(dir_a), 32'd2);
    check_val("a_rom_addr2", 32'(rom_a), 32'd13635);

    // ---- Instance B: song wrap with NOTE_TICKS=2 ----
    rst_b = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      tick(1);
      check_val($sformatf("b_dir_%0d", n), 32'(dir_b), 32'((n / 2) % 25));
      check_val($sformatf("b_cnt_%0d", n), 32'(cnt_b), 32'(n % 2));
      if (n == 48) check_val("b_rom_addr24", 32'(rom_b), 32'd11466);
      if (n == 50) check_val("b_rom_wrap", 32'(rom_b), 32'd15305);
    end

    // ---- Instance C: ROM sweep over all 32 addresses ----
    check_val("c_rom_0", 32'(rom_c), note_of(0));
    rst_c = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      tick(1);
      check_val($sformatf("c_dir_%0d", n), 32'(dir_c), 32'(n % 32));
      check_val($sformatf("c_rom_%0d", n % 32), 32'(rom_c), note_of(n % 32));
      check_val($sformatf("c_cnt_%0d", n), 32'(cnt_c), 32'd0);
    end

    // ---- Instance D: mid-note reset at address 7, count 5 ----
    rst_d = 1'b1;
    tick(75);
    check_val("d_pre_dir", 32'(dir_d), 32'd7);
    check_val("d_pre_cnt", 32'(cnt_d), 32'd5);
    rst_d = 1'b0;
    tick(1);
    check_val("d_rst_dir", 32'(dir_d), 32'd0);
    check_val("d_rst_cnt", 32'(cnt_d), 32'd0);
    rst_d = 1'b1;
    tick(9);
    check_val("d_hold_dir", 32'(dir_d), 32'd0);
    check_val("d_hold_cnt", 32'(cnt_d), 32'd9);
    tick(1);
    check_val("d_next_dir", 32'(dir_d), 32'd1);
    check_val("d_next_cnt", 32'(cnt_d), 32'd0);

    // ---- Instance E: NOTE_TICKS=1, SONG_LEN=1 stays at zero ----
    rst_e = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      tick(1);
      check_val($sformatf("e_dir_%0d", n), 32'(dir_e), 32'd0);
      check_val($sformatf("e_cnt_%0d", n), 32'(cnt_e), 32'd0);
      check_val($sformatf("e_rom_%0d", n), 32'(rom_e), 32'd15305);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
Tune sequencer for the music-box tone generator. It combines the note-timing controller and the note ROM in one block. It steps a 5-bit note address through the "Happy Birthday" melody, holding each note for a fixed number of clock cycles. The ROM translates each address into a half-period cycle count. A downstream square-wave generator toggles the speaker when its own counter reaches `ciclos_de_nota`, so the tone period is 2*(ciclos_de_nota+1) clocks.

Parameters:
- NOTE_TICKS, 6000000, clock cycles per note (0.5 s at 12 MHz); legal range 1..2^24.
- SONG_LEN, 25, number of melody notes played before wrapping to address 0; legal range 1..32.

Ports:
- clk  input  1  system clock, rising-edge active (12 MHz nominal).
- rst_n  input  1  synchronous active-low reset.
- direccion_nota  output  5  current note address (registered).
- contador_tiempo  output  24  cycles elapsed within the current note (registered).
- ciclos_de_nota  output  16  half-period count for the current note (combinational from direccion_nota).

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-low: sampled on the rising edge of clk while rst_n=0.
- Reset values: direccion_nota=0, contador_tiempo=0. Consequently ciclos_de_nota = ROM[0] = 15305.
- Reset overrides counting: asserting rst_n mid-note or mid-song returns to address 0 / count 0 on that edge. No partial state is kept.
- Timer, on each rising edge with rst_n=1:
  - if contador_tiempo == NOTE_TICKS-1, contador_tiempo <= 0 and the address advances;
  - otherwise contador_tiempo <= contador_tiempo + 1.
- Address advance:
  - if direccion_nota == SONG_LEN-1, direccion_nota <= 0;
  - otherwise direccion_nota <= direccion_nota + 1.
  - The advance happens in the same cycle the timer wraps.
- Timing: each address is held exactly NOTE_TICKS cycles. A full song lasts SONG_LEN*NOTE_TICKS cycles.
- Terminal values: contador_tiempo never exceeds NOTE_TICKS-1. direccion_nota never exceeds SONG_LEN-1.
- NOTE_TICKS=1 case: the address advances every cycle and contador_tiempo stays 0.
- ROM:
  - Purely combinational, 32 entries x 16 bits, zero latency. ciclos_de_nota changes in the same cycle as direccion_nota.
  - Contents (decimal): G4=15305, A4=13635, B4=12148, C5=11466, D5=10215, E5=9100, F5=8589, G5=7652.
  - Addr 0-5: G4 G4 A4 G4 C5 B4
  - Addr 6-11: G4 G4 A4 G4 D5 C5
  - Addr 12-18: G4 G4 G5 E5 C5 B4 A4
  - Addr 19-24: F5 F5 E5 C5 D5 C5
  - Addr 25-31: 0. These are unused with the default SONG_LEN and must still decode to 0.
- No X on any output after the first reset edge. Before the first reset, outputs initialise to the reset values (power-up init).

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles mid-run (NOTE_TICKS=4) -> next edge gives direccion_nota=0, contador_tiempo=0, ciclos_de_nota=15305.
2. Note timing with NOTE_TICKS=4, SONG_LEN=25, after reset:
   - contador_tiempo sequence is 0,1,2,3,0;
   - direccion_nota goes 0->1 exactly on the 4th edge;
   - ciclos_de_nota stays 15305 for addresses 0 and 1, then becomes 13635 at address 2.
3. Song wrap with NOTE_TICKS=2: run 50 cycles -> address reaches 24 (ciclos_de_nota=11466), then returns to 0 (15305). Address 25 never appears.
4. ROM sweep: force NOTE_TICKS=1, SONG_LEN=32 -> ciclos_de_nota over 32 consecutive cycles matches the table above, including 0 for addresses 25-31.
5. Mid-note reset: NOTE_TICKS=10, pulse rst_n low for 1 cycle when address=7, count=5 -> address=0, count=0 next edge. The following note boundary occurs 10 cycles later.
6. Edge parameter: NOTE_TICKS=1, SONG_LEN=1 -> direccion_nota and contador_tiempo stay 0 indefinitely, and ciclos_de_nota=15305.
